// File: rtl/uart_recv_ctrl_pkg.sv
// Shared receive-path definitions: state encoding, link word width, default gap timeout.
// The encoding is 2 bits wide so that a corrupted state value can be recovered to IDLE.
package uart_recv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1
  } state_e;

  // Must match the word width used on the transmit side of the PC link.
  localparam int WORD_W = 32;

  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/uart_byte_edge.sv
// Registered rising-edge detector: one-cycle strobe one clock after done_i rises, byte latched in that first high cycle.
// A level held high for many cycles produces a single strobe; no backpressure.
module uart_byte_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_i,
  input  logic [7:0] data_i,
  output logic       strobe_o,
  output logic [7:0] data_o
);

  logic       done_q;
  logic       strobe_q;
  logic [7:0] data_q;
  logic       rise;

  assign rise = done_i & ~done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      done_q   <= done_i;
      strobe_q <= rise;
      if (rise) begin
        data_q <= data_i;
      end
    end
  end

  assign strobe_o = strobe_q;
  assign data_o   = data_q;

endmodule

// File: rtl/uart_recv_ctrl.sv
// Packs UART bytes (first byte in bits [7:0]) into WORD_BYTES-wide words; data_valid rises 2 clocks after the last strobe.
// The output word is held until data_ack; a word completed while the previous one is unacked is dropped and flags overrun.
module uart_recv_ctrl
  import uart_recv_ctrl_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_read_done,
  input  logic [7:0]              read_data,
  input  logic                    data_ack,
  input  logic                    overrun_clr,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    data_valid,
  output logic [CNT_W-1:0]        byte_cnt,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int             WW       = 8 * WORD_BYTES;
  localparam int             GAP_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WW-1:0]    shift_q, shift_d;
  logic [WW-1:0]    dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             to_q, to_d;

  logic             cap_stb;
  logic [7:0]       cap_byte;
  logic [WW-1:0]    full_word;
  logic             word_done;
  logic             ovr_set;

  uart_byte_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .done_i   (uart_read_done),
    .data_i   (read_data),
    .strobe_o (cap_stb),
    .data_o   (cap_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    to_d      = 1'b0;
    word_done = 1'b0;

    // The completing byte bypasses the shift buffer so the word reaches the output one clock earlier.
    full_word = shift_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        full_word[i*8 +: 8] = cap_byte;
      end
    end

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cap_stb) begin
          gap_d = '0;
          if (cnt_q == LAST_LANE) begin
            word_done = 1'b1;
            cnt_d     = '0;
            shift_d   = '0;
            state_d   = ST_IDLE;
          end else begin
            shift_d = full_word;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_COLLECT;
          end
        end else if (state_q == ST_COLLECT) begin
          if (gap_q == GAP_LAST) begin
            to_d    = 1'b1;
            cnt_d   = '0;
            gap_d   = '0;
            shift_d = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else begin
          gap_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gap_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovr_set = 1'b0;

    if (word_done) begin
      if (!vld_q || data_ack) begin
        dout_d = full_word;
        vld_d  = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (vld_q && data_ack) begin
      vld_d = 1'b0;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = vld_q;
  assign byte_cnt   = cnt_q;
  assign overrun    = ovr_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_uart_recv_ctrl.sv
// Directed bench: a default-timeout instance for word/handshake scenarios and a 16-cycle-timeout instance for the gap timer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_recv_ctrl;

  logic        clk;
  logic        rst;
  logic        uart_read_done;
  logic [7:0]  read_data;
  logic        data_ack;
  logic        overrun_clr;

  logic [31:0] dout;
  logic        vld;
  logic [2:0]  cnt;
  logic        ovr;
  logic        to;

  logic [31:0] dout_t;
  logic        vld_t;
  logic [2:0]  cnt_t;
  logic        ovr_t;
  logic        to_t;

  int n_cmp;
  int n_err;

  logic [7:0] basic_bytes [4];

  uart_recv_ctrl #(.WORD_BYTES(4), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_read_done (uart_read_done),
    .read_data      (read_data),
    .data_ack       (data_ack),
    .overrun_clr    (overrun_clr),
    .data_out       (dout),
    .data_valid     (vld),
    .byte_cnt       (cnt),
    .overrun        (ovr),
    .timeout        (to)
  );

  uart_recv_ctrl #(.WORD_BYTES(4), .TIMEOUT_CYCLES(16), .CNT_W(3)) dut_to (
    .clk            (clk),
    .rst            (rst),
    .uart_read_done (uart_read_done),
    .read_data      (read_data),
    .data_ack       (data_ack),
    .overrun_clr    (overrun_clr),
    .data_out       (dout_t),
    .data_valid     (vld_t),
    .byte_cnt       (cnt_t),
    .overrun        (ovr_t),
    .timeout        (to_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts on a falling edge, returns on the next one with the strobe low again.
  task automatic send_byte(input logic [7:0] b);
    uart_read_done = 1'b1;
    read_data      = b;
    @(negedge clk);
    uart_read_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit ack_last);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (i == 3 && ack_last) data_ack = 1'b1;
      if (i < 3) idle(2);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %0h want 0", dout); end
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", vld); end
    n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0h want 0", cnt); end
    n_cmp++; if (ovr !== 1'b0 || to !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ovr=%0h to=%0h want 0 0", ovr, to); end
    n_cmp++; if (vld_t !== 1'b0 || cnt_t !== 3'd0 || to_t !== 1'b0) begin n_err++; $display("FAIL reset_to_inst: got vld=%0h cnt=%0h to=%0h want 0 0 0", vld_t, cnt_t, to_t); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_word();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      send_byte(basic_bytes[i]);
      if (i == 3) begin
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL basic_valid_early: got %0h want 0", vld); end
      end
      @(negedge clk);
      if (i < 3) begin
        n_cmp++; if (cnt !== 3'(i + 1)) begin n_err++; $display("FAIL basic_cnt%0d: got %0d want %0d", i, cnt, i + 1); end
        idle(18);
      end
    end
    n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0h want 1", vld); end
    n_cmp++; if (dout !== 32'h12345678) begin n_err++; $display("FAIL basic_dout: got %0h want 12345678", dout); end
    n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL basic_cnt_wrap: got %0d want 0", cnt); end
    idle(3);
    n_cmp++; if (vld !== 1'b1 || dout !== 32'h12345678) begin n_err++; $display("FAIL basic_hold: got vld=%0h dout=%0h want 1 12345678", vld, dout); end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL basic_ack: got %0h want 0", vld); end
  endtask

  task automatic test_held_strobe();
    pulse_reset();
    uart_read_done = 1'b1;
    read_data      = 8'hAA;
    @(negedge clk);
    read_data      = 8'hBB;
    idle(4);
    uart_read_done = 1'b0;
    idle(2);
    n_cmp++; if (cnt !== 3'd1) begin n_err++; $display("FAIL held_cnt: got %0d want 1", cnt); end
    send_byte(8'h01); idle(2);
    send_byte(8'h02); idle(2);
    send_byte(8'h03);
    @(negedge clk);
    n_cmp++; if (dout !== 32'h030201AA || vld !== 1'b1) begin n_err++; $display("FAIL held_word: got vld=%0h dout=%0h want 1 030201aa", vld, dout); end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int pulses;
    int first_at;
    pulses   = 0;
    first_at = -1;
    pulse_reset();
    send_byte(8'h01); idle(2);
    send_byte(8'h02);
    for (int k = 2; k < 20; k++) begin
      @(negedge clk);
      if (to_t === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
      if (k == 17) begin
        n_cmp++; if (to_t !== 1'b0 || cnt_t !== 3'd2) begin n_err++; $display("FAIL to_before: got to=%0h cnt=%0d want 0 2", to_t, cnt_t); end
      end
      if (k == 18) begin
        n_cmp++; if (to_t !== 1'b1 || cnt_t !== 3'd0) begin n_err++; $display("FAIL to_fire: got to=%0h cnt=%0d want 1 0", to_t, cnt_t); end
      end
    end
    n_cmp++; if (pulses != 1 || first_at != 18) begin n_err++; $display("FAIL to_pulse: got %0d pulses at %0d want 1 at 18", pulses, first_at); end
    idle(3);
    send_word(32'h44332211, 1'b0);
    @(negedge clk);
    n_cmp++; if (dout_t !== 32'h44332211 || vld_t !== 1'b1) begin n_err++; $display("FAIL to_next_word: got vld=%0h dout=%0h want 1 44332211", vld_t, dout_t); end
  endtask

  task automatic test_overrun();
    pulse_reset();
    send_word(32'h0A0B0C0D, 1'b0);
    @(negedge clk);
    n_cmp++; if (dout !== 32'h0A0B0C0D || vld !== 1'b1 || ovr !== 1'b0) begin n_err++; $display("FAIL ovr_wordA: got vld=%0h dout=%0h ovr=%0h want 1 0a0b0c0d 0", vld, dout, ovr); end
    send_word(32'h01020304, 1'b0);
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %0h want 0", ovr); end
    @(negedge clk);
    n_cmp++; if (dout !== 32'h0A0B0C0D || vld !== 1'b1) begin n_err++; $display("FAIL ovr_keepA: got vld=%0h dout=%0h want 1 0a0b0c0d", vld, dout); end
    n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0h want 1", ovr); end
    idle(2);
    n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0h want 1", ovr); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %0h want 0", ovr); end
  endtask

  // Continues from test_overrun with word A still pending.
  task automatic test_ack_complete();
    send_word(32'h01020304, 1'b1);
    @(negedge clk);
    data_ack = 1'b0;
    n_cmp++; if (dout !== 32'h01020304 || vld !== 1'b1) begin n_err++; $display("FAIL ackc_word: got vld=%0h dout=%0h want 1 01020304", vld, dout); end
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ackc_ovr: got %0h want 0", ovr); end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL ackc_drain: got %0h want 0", vld); end
  endtask

  task automatic test_reset_mid_word();
    pulse_reset();
    send_word(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    send_word(32'hCAFEF00D, 1'b0);
    @(negedge clk);
    send_byte(8'h99); idle(2);
    send_byte(8'h88);
    @(negedge clk);
    n_cmp++; if (cnt !== 3'd2 || vld !== 1'b1 || ovr !== 1'b1) begin n_err++; $display("FAIL mid_pre: got cnt=%0d vld=%0h ovr=%0h want 2 1 1", cnt, vld, ovr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (dout !== 32'h0 || vld !== 1'b0 || cnt !== 3'd0 || ovr !== 1'b0 || to !== 1'b0) begin n_err++; $display("FAIL mid_reset: got dout=%0h vld=%0h cnt=%0d ovr=%0h to=%0h want all 0", dout, vld, cnt, ovr, to); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(32'h8D7C6B5A, 1'b0);
    @(negedge clk);
    n_cmp++; if (dout !== 32'h8D7C6B5A || vld !== 1'b1) begin n_err++; $display("FAIL mid_clean: got vld=%0h dout=%0h want 1 8d7c6b5a", vld, dout); end
    n_cmp++; if (ovr !== 1'b0 || to !== 1'b0) begin n_err++; $display("FAIL mid_flags: got ovr=%0h to=%0h want 0 0", ovr, to); end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    uart_read_done = 1'b0;
    read_data      = 8'h00;
    data_ack       = 1'b0;
    overrun_clr    = 1'b0;
    basic_bytes[0] = 8'h78;
    basic_bytes[1] = 8'h56;
    basic_bytes[2] = 8'h34;
    basic_bytes[3] = 8'h12;

    test_reset();
    test_basic_word();
    test_held_strobe();
    test_timeout();
    test_overrun();
    test_ack_complete();
    test_reset_mid_word();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
